i2s_tx_master: RTL

//  I2S transmitter and bus master. Serialises stereo PCM samples from the audio pipeline onto sclk/ws/sdata
//  in Philips I2S format: MSB one bit after the WS edge, WS low = left. Generates sclk and ws from the system clock.

---
 rtl/i2s_tx_master.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/i2s_tx_master.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx_master
// Purpose  : Philips I2S transmitter/bus master; generates sclk/ws, serialises L/R PCM.
//            Optional I2S_TX_UNDERRUN_REPEAT_EN: on underrun retransmit previous pair.
// Revision : 1.0  initial release
// ============================================================================
module i2s_tx_master #(
    parameter int WIDTH     = 16,
    parameter int SLOT_BITS = 32,
    parameter int CLK_DIV   = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] leftChan_i,
    input  logic [WIDTH-1:0] rightChan_i,
    input  logic             sampleValid_i,
    output logic             sampleReady_o,
    output logic             sclk_o,
    output logic             ws_o,
    output logic             sdata_o,
    output logic             pktI2STxLoaded_o,
    output logic             underrun_o
);

    localparam int FB_W  = $clog2(2 * SLOT_BITS);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic             w_running;
    logic             w_draining;
    logic             w_idle_start;

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_sclk;
    logic [FB_W-1:0]  r_frame_bit;
    logic             r_ws;
    logic             r_sdata;
    logic [WIDTH-1:0] r_left;
    logic [WIDTH-1:0] r_right;
    logic [WIDTH-1:0] r_hold_left;
    logic [WIDTH-1:0] r_hold_right;
    logic             r_hold_full;
    logic             r_ready;
    logic             r_loaded;
    logic             r_underrun;

    logic             w_wrap;
    logic             w_fall;
    logic             w_frame_last;
    logic             w_stop;
    logic             w_frame_start;
    logic [FB_W-1:0]  w_next_bit;
    logic             w_next_ws;
    logic [FB_W-1:0]  w_slot_bit;
    logic [WIDTH-1:0] w_chan;
    logic [WIDTH-1:0] w_hit;
    logic             w_next_sdata;
    logic             w_accept;
    logic             w_transfer;
    logic             w_hold_full_next;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (enable_i) w_state_next = S_RUN;
            S_RUN:   if (!enable_i) w_state_next = S_DRAIN;
            S_DRAIN: begin
                if (enable_i) begin
                    w_state_next = S_RUN;
                end else if (w_stop) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_running    = 1'b0;
        w_draining   = 1'b0;
        w_idle_start = 1'b0;
        case (r_state)
            S_IDLE:  w_idle_start = enable_i;
            S_RUN:   w_running    = 1'b1;
            S_DRAIN: begin
                w_running  = 1'b1;
                w_draining = 1'b1;
            end
            default: w_running = 1'b0;
        endcase
    end

    // ---------------- Timing and bit selection ----------------
    assign w_wrap        = w_running && (r_div_cnt == DIV_W'(CLK_DIV - 1));
    assign w_fall        = w_wrap && r_sclk;
    assign w_frame_last  = (r_frame_bit == FB_W'(2 * SLOT_BITS - 1));
    // Draining ends on the fall that would begin a new frame
    assign w_stop        = w_fall && w_frame_last && w_draining && !enable_i;
    assign w_frame_start = w_idle_start || (w_fall && w_frame_last && !w_stop);

    assign w_next_bit = w_frame_last ? '0 : r_frame_bit + 1'b1;
    assign w_next_ws  = (w_next_bit >= FB_W'(SLOT_BITS));
    assign w_slot_bit = w_next_ws ? (w_next_bit - FB_W'(SLOT_BITS)) : w_next_bit;
    assign w_chan     = w_next_ws ? r_right : r_left;

    // Slot bit k (1..WIDTH) carries chan[WIDTH-k]; bit 0 is the I2S delay bit
    generate
        for (genvar k = 1; k <= WIDTH; k++) begin : g_sdata_sel
            assign w_hit[k-1] = (w_slot_bit == FB_W'(k)) & w_chan[WIDTH-k];
        end
    endgenerate
    assign w_next_sdata = |w_hit;

    assign w_accept         = sampleValid_i && r_ready;
    assign w_transfer       = w_frame_start && r_hold_full;
    assign w_hold_full_next = w_accept ? 1'b1 : (w_transfer ? 1'b0 : r_hold_full);

    // ---------------- Datapath ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_div_cnt    <= '0;
            r_sclk       <= 1'b0;
            r_frame_bit  <= '0;
            r_ws         <= 1'b0;
            r_sdata      <= 1'b0;
            r_left       <= '0;
            r_right      <= '0;
            r_hold_left  <= '0;
            r_hold_right <= '0;
            r_hold_full  <= 1'b0;
            r_ready      <= 1'b0;
            r_loaded     <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            if (!w_running || w_stop) begin
                r_div_cnt   <= '0;
                r_sclk      <= 1'b0;
                r_frame_bit <= '0;
                r_ws        <= 1'b0;
                r_sdata     <= 1'b0;
            end else begin
                r_div_cnt <= w_wrap ? '0 : r_div_cnt + 1'b1;
                if (w_wrap) begin
                    r_sclk <= ~r_sclk;
                end
                if (w_fall) begin
                    r_frame_bit <= w_next_bit;
                    r_ws        <= w_next_ws;
                    r_sdata     <= w_next_sdata;
                end
            end

            if (w_frame_start) begin
                if (r_hold_full) begin
                    r_left  <= r_hold_left;
                    r_right <= r_hold_right;
                end else begin
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
                    r_left  <= r_left;
                    r_right <= r_right;
`else
                    r_left  <= '0;
                    r_right <= '0;
`endif
                end
            end

            if (w_accept) begin
                r_hold_left  <= leftChan_i;
                r_hold_right <= rightChan_i;
            end
            r_hold_full <= w_hold_full_next;
            r_ready     <= !w_hold_full_next;
            r_loaded    <= w_transfer;
            r_underrun  <= w_frame_start && !r_hold_full;
        end
    end

    assign sampleReady_o    = r_ready;
    assign sclk_o           = r_sclk;
    assign ws_o             = r_ws;
    assign sdata_o          = r_sdata;
    assign pktI2STxLoaded_o = r_loaded;
    assign underrun_o       = r_underrun;

endmodule
`default_nettype wire
